vmvmb_grad_bp: RTL
==================

// Module: vmvmb_grad_bp
// PURPOSE
// Backward-pass counterpart of the gate pre-activation stage A = Wx'x + Wh'h_prev + b.
// Accepts the gate gradient dA (N_OUT elements) as a stream and buffers it.
// Computes dx[i] = sum_j Wx[i][j]*dA[j] and dh[i] = sum_j Wh[i][j]*dA[j], one row at a time.
// Uses one MAC per matrix; Wx/Wh are read from external weight RAM.
// Emits (dx[i], dh[i]) pairs as a stream in row order i = 0..N_IN-1.
// db = dA and is taken upstream; this block does not produce it.
// PARAMETERS
// N_IN   100  rows of Wx/Wh; length of x, h_prev, dx, dh
// N_OUT  400  cols of Wx/Wh; length of dA
// DW     32   signed data width of dA, weights, dx, dh
// PORTS
// clk        in   1               single clock, rising edge
// rst_n      in   1               async active-low reset
// da_valid   in   1               dA element valid
// da_ready   out  1               block can accept a dA element
// da_data    in   DW              dA[j], j = beat count 0..N_OUT-1
// w_rd_en    out  1               weight read strobe
// w_row      out  $clog2(N_IN)    weight row address i
// w_col      out  $clog2(N_OUT)   weight column address j
// wx_rdata   in   DW              Wx[w_row][w_col]; valid 1 cycle after w_rd_en
// wh_rdata   in   DW              Wh[w_row][w_col]; valid 1 cycle after w_rd_en
// out_valid  out  1               dx/dh result valid
// out_ready  in   1               downstream accepts result
// dx_data    out  DW              dx[out_idx]
// dh_data    out  DW              dh[out_idx]
// out_idx    out  $clog2(N_IN)    row index of current result
// out_last   out  1               high with out_valid when out_idx == N_IN-1
// busy       out  1               high in every state except IDLE
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, all counters and accumulators = 0.
// - Reset values: da_ready=0, w_rd_en=0, w_row=0, w_col=0, out_valid=0,
//   dx_data=0, dh_data=0, out_idx=0, out_last=0, busy=0.
// - FSM states: IDLE, LOAD, MAC, DRAIN, EMIT.
// - IDLE: da_ready=1. Handshake (da_valid&da_ready) stores buf[0] and enters LOAD with j=1.
// - LOAD: da_ready=1; each handshake stores buf[j], j++. The handshake with j==N_OUT-1
//   enters MAC, row=0, col=0, and clears both accumulators. da_ready=0 outside IDLE/LOAD.
// - MAC: w_rd_en=1 each cycle, w_row=row, w_col=col, col++. After the col==N_OUT-1 issue -> DRAIN.
//   One cycle after each issue: accx += wx_rdata*buf[col_d]; acch += wh_rdata*buf[col_d].
//   col_d is the issued column delayed by one cycle.
// - DRAIN: one cycle; last product accumulated, w_rd_en=0 -> EMIT.
// - Row latency: N_OUT+1 cycles from first issue to EMIT entry.
// - EMIT: out_valid=1 with dx_data=accx, dh_data=acch, out_idx=row; hold all until out_ready.
//   On handshake: if row==N_IN-1 -> IDLE; else row++, col=0, accumulators cleared -> MAC.
// - Arithmetic: full 2*DW signed product; accumulator keeps the low DW bits (two's-complement wrap).
//   No saturation; this matches the forward path's 32-bit wrap.
// - dA buffer is overwritten only in IDLE/LOAD. A new dA stream is not accepted until the last result handshakes.
// - out_ready is ignored outside EMIT. da_valid is ignored outside IDLE/LOAD (no stall, no drop counted).
// - rst_n asserted mid-LOAD/MAC/EMIT: immediate abort. Partial dA and partial sums are discarded.
//   The next dA stream restarts at j=0.
// TESTING (bench at N_IN=2, N_OUT=3 unless noted)
// - Reset: rst_n=0 mid-MAC -> every output is 0 next cycle; after release, da_ready=1 and busy=0.
// - Basic: dA=[1,2,3], Wx=[[1,0,0],[0,1,1]], Wh=[[2,2,2],[-1,0,1]]
//   -> (dx,dh) = (1,12) idx0, then (5,2) idx1 with out_last=1.
// - Backpressure: out_ready held 0 for 5 cycles in EMIT -> data/idx stable, no w_rd_en; resumes correctly.
// - Input stall: da_valid toggles 1,0,1,0,1 -> 3 elements stored in order; result equals the Basic case.
// - Wrap: dA=[0x7FFFFFFF,...], Wx[0][0]=2, rest 0 -> dx[0]=0xFFFFFFFE (low 32 bits).
// - Default params: random dA/Wx/Wh vs golden model -> 100 rows match; cycles/row = 401 + EMIT stall.

Source files
------------

// File: rtl/vmvmb_grad_bp.sv
// Backward pass of the gate pre-activation stage: buffers dA, then streams
// dx = Wx*dA and dh = Wh*dA one row at a time using one MAC per matrix.
module vmvmb_grad_bp #(
   parameter int unsigned N_IN  = 100,
   parameter int unsigned N_OUT = 400,
   parameter int unsigned DW    = 32,
   localparam int unsigned RW   = (N_IN > 1) ? $clog2(N_IN) : 1,
   localparam int unsigned CW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          da_valid,
   output logic          da_ready,
   input  logic [DW-1:0] da_data,
   output logic          w_rd_en,
   output logic [RW-1:0] w_row,
   output logic [CW-1:0] w_col,
   input  logic [DW-1:0] wx_rdata,
   input  logic [DW-1:0] wh_rdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] dx_data,
   output logic [DW-1:0] dh_data,
   output logic [RW-1:0] out_idx,
   output logic          out_last,
   output logic          busy
);

   typedef enum logic [2:0] {StIdle, StLoad, StMac, StDrain, StEmit} state_e;

   state_e          state_q;
   logic [CW-1:0]   j_q;
   logic [CW-1:0]   col_d_q;
   logic            acc_vld_q;
   logic [DW-1:0]   accx_q, acch_q;
   logic [DW-1:0]   accx_d, acch_d;
   logic [DW-1:0]   dabuf_q [N_OUT];

   logic            da_ready_q, w_rd_en_q, out_valid_q, out_last_q, busy_q;
   logic [RW-1:0]   w_row_q, out_idx_q;
   logic [CW-1:0]   w_col_q;
   logic [DW-1:0]   dx_q, dh_q;

   logic            da_hs, last_beat, last_col, last_row;
   logic [DW-1:0]   buf_rd, prodx, prodh;

   assign da_hs     = da_valid & da_ready_q;
   assign last_beat = (j_q == CW'(N_OUT - 1));
   assign last_col  = (w_col_q == CW'(N_OUT - 1));
   assign last_row  = (w_row_q == RW'(N_IN - 1));

   // The low DW bits of a two's-complement product do not depend on signedness,
   // so a DW-wide multiply yields exactly the wrapped low half of the full product.
   assign buf_rd = dabuf_q[col_d_q];
   assign prodx  = wx_rdata * buf_rd;
   assign prodh  = wh_rdata * buf_rd;
   assign accx_d = acc_vld_q ? accx_q + prodx : accx_q;
   assign acch_d = acc_vld_q ? acch_q + prodh : acch_q;

   always_ff @(posedge clk) begin
      if (da_hs) begin
         dabuf_q[j_q] <= da_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         j_q         <= '0;
         col_d_q     <= '0;
         acc_vld_q   <= 1'b0;
         accx_q      <= '0;
         acch_q      <= '0;
         da_ready_q  <= 1'b0;
         w_rd_en_q   <= 1'b0;
         w_row_q     <= '0;
         w_col_q     <= '0;
         out_valid_q <= 1'b0;
         dx_q        <= '0;
         dh_q        <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         // Read data returns one cycle after the issue, so the column is delayed to match.
         acc_vld_q <= w_rd_en_q;
         col_d_q   <= w_col_q;
         accx_q    <= accx_d;
         acch_q    <= acch_d;
         unique case (state_q)
            StIdle, StLoad: begin
               da_ready_q <= 1'b1;
               if (da_hs) begin
                  busy_q <= 1'b1;
                  if (last_beat) begin
                     state_q    <= StMac;
                     j_q        <= '0;
                     da_ready_q <= 1'b0;
                     w_rd_en_q  <= 1'b1;
                     w_row_q    <= '0;
                     w_col_q    <= '0;
                     accx_q     <= '0;
                     acch_q     <= '0;
                  end else begin
                     state_q <= StLoad;
                     j_q     <= j_q + CW'(1);
                  end
               end
            end
            StMac: begin
               if (last_col) begin
                  state_q   <= StDrain;
                  w_rd_en_q <= 1'b0;
               end else begin
                  w_col_q <= w_col_q + CW'(1);
               end
            end
            StDrain: begin
               state_q     <= StEmit;
               out_valid_q <= 1'b1;
               dx_q        <= accx_d;
               dh_q        <= acch_d;
               out_idx_q   <= w_row_q;
               out_last_q  <= last_row;
            end
            StEmit: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  w_col_q     <= '0;
                  if (last_row) begin
                     state_q    <= StIdle;
                     busy_q     <= 1'b0;
                     da_ready_q <= 1'b1;
                     w_row_q    <= '0;
                  end else begin
                     state_q   <= StMac;
                     w_row_q   <= w_row_q + RW'(1);
                     w_rd_en_q <= 1'b1;
                     accx_q    <= '0;
                     acch_q    <= '0;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign da_ready  = da_ready_q;
   assign w_rd_en   = w_rd_en_q;
   assign w_row     = w_row_q;
   assign w_col     = w_col_q;
   assign out_valid = out_valid_q;
   assign dx_data   = dx_q;
   assign dh_data   = dh_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

endmodule
